// File: rtl/pid_pkg.sv
// Shared types and helpers for the PID steering controller.
// sat_s clips a sign-extended value to a signed w-bit range.
package pid_pkg;

  typedef enum logic [1:0] {
    MODE_PID     = 2'b00,
    MODE_PI      = 2'b01,
    MODE_P       = 2'b10,
    MODE_PID_ALT = 2'b11
  } mode_e;

  localparam int CLIP_W = 32;

  function automatic logic signed [CLIP_W-1:0] sat_s(
    input logic signed [CLIP_W-1:0] v,
    input int                       w
  );
    logic signed [CLIP_W-1:0] hi;
    logic signed [CLIP_W-1:0] lo;
    hi = (CLIP_W'(1) <<< (w - 1)) - CLIP_W'(1);
    lo = ~hi;
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction

endpackage

// File: rtl/pid_dhist.sv
// Error history for the derivative term: a DEPTH-deep shift register that
// loads on each new sample and exposes the oldest entry.
module pid_dhist #(
  parameter int W     = 10,
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ld_i,
  input  logic signed [W-1:0] d_i,
  output logic signed [W-1:0] oldest_o
);

  logic signed [W-1:0] hist_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) hist_q[i] <= '0;
    end else if (ld_i) begin
      hist_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) hist_q[i] <= hist_q[i-1];
    end
  end

  assign oldest_o = hist_q[DEPTH-1];

endmodule

// File: rtl/pid_ctrl.sv
// Two-stage PID steering controller: stage 1 captures error, derivative and
// integrator; stage 2 forms the P+I+D sum and the clipped wheel speeds.
module pid_ctrl
  import pid_pkg::*;
#(
  parameter int ERR_W   = 12,
  parameter int SAT_W   = 10,
  parameter int FRWRD_W = 10,
  parameter int SPD_W   = 11,
  parameter int P_COEFF = 16,
  parameter int D_COEFF = 7,
  parameter int D_DEPTH = 2,
  parameter int D_SAT_W = 8,
  parameter int I_W     = 15,
  parameter int I_SHIFT = 6,
  parameter int PID_W   = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     moving,
  input  logic                     err_vld,
  input  logic signed [ERR_W-1:0]  error,
  input  logic [FRWRD_W-1:0]       frwrd,
  input  logic [1:0]               mode,
  output logic signed [SPD_W-1:0]  lft_spd,
  output logic signed [SPD_W-1:0]  rght_spd,
  output logic                     out_vld,
  output logic                     sat
);

  localparam int SUM_W = ((FRWRD_W + 1 > PID_W) ? FRWRD_W + 1 : PID_W) + 1;

  mode_e                    mode_s;
  logic signed [SAT_W-1:0]  err_sat;
  logic signed [SAT_W-1:0]  hist_old;
  logic signed [SAT_W-1:0]  err_q;
  logic signed [D_SAT_W-1:0] diff_q, diff_d;
  logic signed [CLIP_W-1:0] diff_raw;
  logic signed [I_W-1:0]    integ_q, integ_d;
  logic signed [I_W:0]      integ_sum;
  logic                     integ_ovf;
  logic                     windup;
  logic                     vld1_q;

  logic signed [CLIP_W-1:0] p_term, i_term, d_term;
  logic signed [PID_W-1:0]  pid;
  logic signed [SUM_W-1:0]  lsum, rsum;
  logic signed [CLIP_W-1:0] lsum_x, rsum_x;
  logic signed [SPD_W-1:0]  lft_q, lft_d, rght_q, rght_d;
  logic                     sat_q, sat_d;
  logic                     out_vld_q;
  logic                     pid_neg_q;

  assign mode_s  = mode_e'(mode);
  assign err_sat = SAT_W'(sat_s(CLIP_W'(error), SAT_W));

  pid_dhist #(
    .W     (SAT_W),
    .DEPTH (D_DEPTH)
  ) u_dhist (
    .clk      (clk),
    .rst      (rst),
    .ld_i     (err_vld),
    .d_i      (err_sat),
    .oldest_o (hist_old)
  );

  assign diff_raw = CLIP_W'(err_sat) - CLIP_W'(hist_old);
  assign diff_d   = D_SAT_W'(sat_s(diff_raw, D_SAT_W));

  // Integrator holds on overflow, and while the outputs are clipped in the
  // direction this error would push them further.
  assign integ_sum = (I_W+1)'(integ_q) + (I_W+1)'(err_sat);
  assign integ_ovf = integ_sum[I_W] ^ integ_sum[I_W-1];
  assign windup    = sat_q && (err_sat[SAT_W-1] == pid_neg_q);

  always_comb begin
    integ_d = integ_q;
    if (!moving) begin
      integ_d = '0;
    end else if (err_vld && mode_s != MODE_P && !integ_ovf && !windup) begin
      integ_d = integ_sum[I_W-1:0];
    end
  end

  always_comb begin
    p_term = CLIP_W'(err_q) * CLIP_W'(P_COEFF);
    i_term = '0;
    d_term = '0;
    if (mode_s != MODE_P) begin
      i_term = CLIP_W'(integ_q) >>> I_SHIFT;
    end
    if (mode_s == MODE_PID || mode_s == MODE_PID_ALT) begin
      d_term = CLIP_W'(diff_q) * CLIP_W'(D_COEFF);
    end
  end

  assign pid    = PID_W'(p_term + i_term + d_term);
  assign lsum   = SUM_W'(frwrd) + SUM_W'(pid);
  assign rsum   = SUM_W'(frwrd) - SUM_W'(pid);
  assign lsum_x = CLIP_W'(lsum);
  assign rsum_x = CLIP_W'(rsum);

  always_comb begin
    lft_d  = '0;
    rght_d = '0;
    sat_d  = 1'b0;
    if (moving) begin
      lft_d  = SPD_W'(sat_s(lsum_x, SPD_W));
      rght_d = SPD_W'(sat_s(rsum_x, SPD_W));
      sat_d  = (sat_s(lsum_x, SPD_W) != lsum_x) || (sat_s(rsum_x, SPD_W) != rsum_x);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q     <= '0;
      diff_q    <= '0;
      integ_q   <= '0;
      vld1_q    <= 1'b0;
      lft_q     <= '0;
      rght_q    <= '0;
      sat_q     <= 1'b0;
      out_vld_q <= 1'b0;
      pid_neg_q <= 1'b0;
    end else begin
      if (err_vld) begin
        err_q  <= err_sat;
        diff_q <= diff_d;
      end
      integ_q   <= integ_d;
      vld1_q    <= err_vld;
      lft_q     <= lft_d;
      rght_q    <= rght_d;
      sat_q     <= sat_d;
      out_vld_q <= vld1_q & moving;
      pid_neg_q <= pid[PID_W-1];
    end
  end

  assign lft_spd  = lft_q;
  assign rght_spd = rght_q;
  assign sat      = sat_q;
  assign out_vld  = out_vld_q;

endmodule

// File: tb/tb_pid_ctrl.sv
// Bench for pid_ctrl: directed scenarios with known values, then random
// traffic, all compared against a cycle-level arithmetic reference model.
module tb_pid_ctrl;

  localparam int ERR_W = 12, SAT_W = 10, FRWRD_W = 10, SPD_W = 11;
  localparam int P_COEFF = 16, D_COEFF = 7, D_DEPTH = 2, D_SAT_W = 8;
  localparam int I_W = 15, I_SHIFT = 6, PID_W = 14;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    moving;
  logic                    err_vld;
  logic signed [ERR_W-1:0] error;
  logic [FRWRD_W-1:0]      frwrd;
  logic [1:0]              mode;
  logic signed [SPD_W-1:0] lft_spd;
  logic signed [SPD_W-1:0] rght_spd;
  logic                    out_vld;
  logic                    sat;

  int n_pass = 0;
  int n_tot  = 0;

  pid_ctrl #(
    .ERR_W(ERR_W), .SAT_W(SAT_W), .FRWRD_W(FRWRD_W), .SPD_W(SPD_W),
    .P_COEFF(P_COEFF), .D_COEFF(D_COEFF), .D_DEPTH(D_DEPTH), .D_SAT_W(D_SAT_W),
    .I_W(I_W), .I_SHIFT(I_SHIFT), .PID_W(PID_W)
  ) dut (
    .clk(clk), .rst(rst), .moving(moving), .err_vld(err_vld), .error(error),
    .frwrd(frwrd), .mode(mode), .lft_spd(lft_spd), .rght_spd(rght_spd),
    .out_vld(out_vld), .sat(sat)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model state
  int m_err, m_diff, m_integ, m_lft, m_rght;
  bit m_vld1, m_ovld, m_sat, m_pidneg;
  int m_hist[$];

  function automatic int clip(int v, int w);
    int hi = (1 <<< (w - 1)) - 1;
    int lo = -(1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic int wrap(int v, int w);
    int m = 1 <<< w;
    int r = v & (m - 1);
    if (r >= (m >>> 1)) r = r - m;
    return r;
  endfunction

  task automatic m_reset();
    m_err = 0; m_diff = 0; m_integ = 0; m_lft = 0; m_rght = 0;
    m_vld1 = 0; m_ovld = 0; m_sat = 0; m_pidneg = 0;
    m_hist = {};
    for (int i = 0; i < D_DEPTH; i++) m_hist.push_back(0);
  endtask

  task automatic m_edge();
    int es, p, i, d, pid, ls, rs, ni, s, e, f;
    bit ns;
    if (rst) begin
      m_reset();
      return;
    end
    e  = error;
    f  = frwrd;
    es = clip(e, SAT_W);
    p  = m_err * P_COEFF;
    i  = (mode == 2'b10) ? 0 : (m_integ >>> I_SHIFT);
    d  = (mode == 2'b10 || mode == 2'b01) ? 0 : m_diff * D_COEFF;
    pid = wrap(p + i + d, PID_W);
    ls = f + pid;
    rs = f - pid;
    ns = moving && (clip(ls, SPD_W) != ls || clip(rs, SPD_W) != rs);
    ni = m_integ;
    if (!moving) ni = 0;
    else if (err_vld && mode != 2'b10) begin
      s = m_integ + es;
      if (s <= (1 <<< (I_W - 1)) - 1 && s >= -(1 <<< (I_W - 1)) &&
          !(m_sat && ((es < 0) == m_pidneg)))
        ni = s;
    end
    if (err_vld) begin
      m_diff = clip(es - m_hist[D_DEPTH-1], D_SAT_W);
      m_err  = es;
      m_hist.push_front(es);
      void'(m_hist.pop_back());
    end
    m_ovld   = m_vld1 && moving;
    m_vld1   = err_vld;
    m_integ  = ni;
    m_lft    = moving ? clip(ls, SPD_W) : 0;
    m_rght   = moving ? clip(rs, SPD_W) : 0;
    m_sat    = ns;
    m_pidneg = (pid < 0);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_tot++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_lft"},   lft_spd,     m_lft);
    chk({tag, "_rght"},  rght_spd,    m_rght);
    chk({tag, "_vld"},   out_vld,     m_ovld);
    chk({tag, "_sat"},   sat,         m_sat);
    chk({tag, "_integ"}, dut.integ_q, m_integ);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    m_edge();
    #1;
    chk_all(tag);
  endtask

  task automatic sample(input string tag, input int e);
    error   = ERR_W'(e);
    err_vld = 1'b1;
    step({tag, "_issue"});
    err_vld = 1'b0;
    step({tag, "_out"});
  endtask

  initial begin
    rst = 1'b1; moving = 1'b1; err_vld = 1'b0; error = '0;
    frwrd = 10'h100; mode = 2'b10;
    m_reset();
    #1;
    chk_all("reset");
    chk("reset_lft_const", lft_spd, 0);
    step("reset_hold");
    rst = 1'b0;
    step("idle");

    // P mode, +20
    sample("p_mode", 20);
    chk("p_lft", lft_spd, 576);
    chk("p_rght", rght_spd, -64);
    chk("p_vld", out_vld, 1);
    chk("p_sat", sat, 0);
    step("p_after");
    chk("p_vld_drop", out_vld, 0);

    // Error saturation
    sample("satur", 12'h7FF);
    chk("satur_lft", lft_spd, 1023);
    chk("satur_rght", rght_spd, -1024);
    chk("satur_sat", sat, 1);

    // Integrator in PI mode
    mode = 2'b01;
    moving = 1'b0;
    step("pi_clear");
    moving = 1'b1;
    for (int k = 0; k < 8; k++) begin
      error = 12'sd8;
      err_vld = 1'b1;
      step("pi_issue");
      err_vld = 1'b0;
      if (k == 7) chk("pi_integ", dut.integ_q, 64);
      step("pi_out");
    end
    chk("pi_lft", lft_spd, 385);
    chk("pi_rght", rght_spd, 127);

    // Anti-windup
    for (int k = 0; k < 4; k++) sample("aw", 12'h7FF);
    chk("aw_integ", dut.integ_q, 575);
    chk("aw_sat", sat, 1);

    // Moving drop clears integrator and speeds
    moving = 1'b0;
    step("stop");
    chk("stop_lft", lft_spd, 0);
    chk("stop_rght", rght_spd, 0);
    chk("stop_integ", dut.integ_q, 0);
    moving = 1'b1;

    // Derivative in PID mode
    mode = 2'b00;
    sample("d0", 0);
    sample("d1", 0);
    sample("d2", 10);
    chk("d_lft", lft_spd, 486);
    chk("d_rght", rght_spd, 26);

    // Frwrd change without a sample
    frwrd = 10'h080;
    step("frwrd_chg");
    chk("frwrd_vld", out_vld, 0);
    frwrd = 10'h100;

    // Reset mid-pipeline
    error = 12'sd50;
    err_vld = 1'b1;
    step("mid_issue");
    #2;
    rst = 1'b1;
    m_reset();
    #1;
    chk_all("mid_rst");
    chk("mid_rst_lft", lft_spd, 0);
    err_vld = 1'b0;
    step("mid_hold");
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step("mid_post");
      chk("mid_no_vld", out_vld, 0);
    end

    // Random traffic
    for (int k = 0; k < 400; k++) begin
      int r;
      moving  = ($urandom_range(0, 19) != 0);
      err_vld = moving && ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) error = ERR_W'($urandom);
      else begin
        r = int'($urandom_range(0, 160)) - 80;
        error = ERR_W'(r);
      end
      if ($urandom_range(0, 7) == 0) frwrd = FRWRD_W'($urandom);
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom);
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
